// File: rtl/instr_byte_fetch.sv
// instr_byte_fetch: walks a program counter through memory one byte at a time,
// keeps up to DEPTH reads in flight, buffers in-order responses with their fetch
// address, and hands them to the frontend. A redirect restarts fetch at a new PC
// and marks every read already in flight as stale so its data is discarded.
module instr_byte_fetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [15:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [7:0]  mem_resp_data,
   output logic [7:0]  instr,
   output logic [15:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [15:0]   pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] stale_q, stale_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          hold_q, hold_d;
   logic [15:0]   fifo_addr_q [DEPTH];
   logic [15:0]   fifo_addr_d [DEPTH];
   logic [7:0]    fifo_data_q [DEPTH];
   logic [7:0]    fifo_data_d [DEPTH];

   logic [CW:0]   credit_used;
   logic          req_hs;
   logic          resp_ok;
   logic          push;
   logic          pop;
   logic [15:0]   push_addr;

   // Outputs: credit-limited request, FIFO head presented unless a redirect is in progress
   always_comb begin
      credit_used   = {1'b0, count_q} + {1'b0, outstanding_q};
      mem_req_valid = ~hold_q & (credit_used < DEPTH_C);
      mem_req_addr  = pc_q;
      instr_valid   = (count_q != '0) & ~redirect;
      instr         = fifo_data_q[rd_ptr_q];
      instr_pc      = fifo_addr_q[rd_ptr_q];
   end

   // Next state: PC advance, in-flight/stale bookkeeping, FIFO push/pop, redirect flush
   always_comb begin
      req_hs  = mem_req_valid & mem_req_ready;
      resp_ok = mem_resp_valid & (outstanding_q != '0);
      push    = resp_ok & (stale_q == '0) & ~redirect;
      pop     = instr_valid & instr_ready;
      // When nothing stale remains, every in-flight read came from consecutive PCs
      // ending at pc_q-1, so the oldest one was issued at pc_q - outstanding_q.
      push_addr = pc_q - 16'(outstanding_q);

      pc_d          = req_hs ? pc_q + 16'd1 : pc_q;
      outstanding_d = outstanding_q + CW'(req_hs) - CW'(resp_ok);
      stale_d       = stale_q - CW'(resp_ok & (stale_q != '0));
      count_d       = count_q + CW'(push) - CW'(pop);
      wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d      = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      hold_d        = 1'b0;

      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      if (push) begin
         fifo_addr_d[wr_ptr_q] = push_addr;
         fifo_data_d[wr_ptr_q] = mem_resp_data;
      end

      // Everything still in flight after this cycle's traffic belongs to the old stream.
      if (redirect) begin
         pc_d     = redirect_pc;
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         stale_d  = outstanding_d;
      end
   end

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         stale_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         hold_q        <= 1'b1;
      end else begin
         pc_q          <= pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         stale_q       <= stale_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         hold_q        <= hold_d;
      end
   end

   // FIFO storage; contents are meaningless while count is zero, so no reset
   always_ff @(posedge clk) begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
   end

   // A response with nothing in flight is a memory protocol error
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(mem_resp_valid && (outstanding_q == '0)))
            else $error("instr_byte_fetch: response with no read outstanding");
      end
   end

endmodule

// File: tb/tb_instr_byte_fetch.sv
// Bench for instr_byte_fetch: a behavioural memory with programmable latency and a
// queue-based reference model (FIFO of fetched bytes, list of in-flight reads with a
// stale mark) checked every cycle, plus directed scenarios and a random phase.
module tb_instr_byte_fetch;

   localparam int unsigned DEPTH    = 4;
   localparam logic [15:0] RESET_PC = 16'h0200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [15:0] mem_req_addr;
   logic        mem_resp_valid = 1'b0;
   logic [7:0]  mem_resp_data = '0;
   logic [7:0]  instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;

   always #5 clk = ~clk;

   instr_byte_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready)
   );

   typedef struct { logic [15:0] addr; bit stale; } infl_t;
   typedef struct { logic [15:0] addr; logic [7:0] data; } ent_t;
   typedef struct { logic [7:0] data; int due; } mresp_t;

   int ntests = 0;
   int nfail  = 0;

   // reference model
   logic [15:0] m_pc;
   bit          m_hold;
   ent_t        m_fifo[$];
   infl_t       m_infl[$];

   // memory and logs
   mresp_t      mem_q[$];
   int          lat = 1;
   int          cyc = 0;
   int          since_rst = 0;
   int          first_valid = -1;
   int          hs_count = 0;
   logic [15:0] hs_addr[$];
   logic [15:0] pop_pc[$];
   logic [7:0]  pop_dat[$];

   function automatic logic [7:0] memfn(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp)
         else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
   endtask

   task automatic clear_logs();
      pop_pc.delete();
      pop_dat.delete();
      hs_addr.delete();
      hs_count = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      redirect = 1'b0;
      instr_ready = 1'b0;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      @(posedge clk);
      m_pc = RESET_PC;
      m_hold = 1'b1;
      m_fifo.delete();
      m_infl.delete();
      mem_q.delete();
      since_rst = 0;
      first_valid = -1;
      clear_logs();
   endtask

   // one clock cycle: drive at negedge, check against the model, then advance the model
   task automatic step(input bit redir, input logic [15:0] rpc, input bit iready, input bit mready);
      bit    ev;
      bit    hs;
      bit    pop;
      infl_t r;
      @(negedge clk);
      rst = 1'b0;
      redirect = redir;
      redirect_pc = rpc;
      instr_ready = iready;
      mem_req_ready = mready;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         mem_resp_valid = 1'b1;
         mem_resp_data = mem_q[0].data;
      end else begin
         mem_resp_valid = 1'b0;
         mem_resp_data = 8'($urandom);
      end
      #1;
      ev = !m_hold && (m_fifo.size() + m_infl.size() < DEPTH);
      chk("req_valid", 32'(mem_req_valid), 32'(ev));
      chk("req_addr", 32'(mem_req_addr), 32'(m_pc));
      chk("instr_valid", 32'(instr_valid), 32'(m_fifo.size() != 0 && !redir));
      if (m_fifo.size() != 0) begin
         chk("instr", 32'(instr), 32'(m_fifo[0].data));
         chk("instr_pc", 32'(instr_pc), 32'(m_fifo[0].addr));
      end

      // memory reacts to what the DUT actually drives
      if (mem_resp_valid) void'(mem_q.pop_front());
      if (mem_req_valid && mready) begin
         mem_q.push_back('{data: memfn(mem_req_addr), due: cyc + lat});
         hs_addr.push_back(mem_req_addr);
         hs_count++;
      end
      if (instr_valid && iready) begin
         pop_pc.push_back(instr_pc);
         pop_dat.push_back(instr);
      end
      if (instr_valid && first_valid < 0) first_valid = since_rst;

      // model update
      hs  = ev && mready;
      pop = (m_fifo.size() != 0) && !redir && iready;
      if (pop) void'(m_fifo.pop_front());
      if (mem_resp_valid && m_infl.size() != 0) begin
         r = m_infl.pop_front();
         if (!r.stale && !redir) m_fifo.push_back('{addr: r.addr, data: memfn(r.addr)});
      end
      if (hs) begin
         m_infl.push_back('{addr: m_pc, stale: 1'b0});
         m_pc = m_pc + 16'd1;
      end
      if (redir) begin
         m_fifo.delete();
         foreach (m_infl[i]) m_infl[i].stale = 1'b1;
         m_pc = rpc;
      end
      m_hold = 1'b0;
      @(posedge clk);
      cyc++;
      since_rst++;
   endtask

   task automatic run(input int n, input bit iready, input bit mready);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, iready, mready);
   endtask

   task automatic chk_pops(input string tag, input logic [15:0] first_pc, input int n);
      logic [15:0] a;
      chk({tag, "_count"}, 32'(pop_pc.size() >= n), 32'd1);
      for (int i = 0; i < n && i < pop_pc.size(); i++) begin
         a = first_pc + 16'(i);
         chk({tag, "_pc"}, 32'(pop_pc[i]), 32'(a));
         chk({tag, "_data"}, 32'(pop_dat[i]), 32'(memfn(a)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: streaming from reset, latency 1
      lat = 1;
      do_reset();
      run(14, 1'b1, 1'b1);
      chk("t1_first_valid", 32'(first_valid), 32'd3);
      chk_pops("t1", 16'h0200, 8);

      // 2: frontend stalled, credit limit, then drain and resume
      do_reset();
      run(10, 1'b0, 1'b1);
      chk("t2_requests", 32'(hs_count), 32'(DEPTH));
      chk("t2_req_valid_low", 32'(mem_req_valid), 32'd0);
      clear_logs();
      run(8, 1'b1, 1'b1);
      chk_pops("t2", 16'h0200, 4);
      chk("t2_resume_addr", 32'(hs_addr.size() > 0 ? hs_addr[0] : 16'hxxxx), 32'h0204);

      // 3: latency 3, redirect with three reads outstanding
      lat = 3;
      do_reset();
      run(4, 1'b1, 1'b1);
      clear_logs();
      step(1'b1, 16'h1234, 1'b1, 1'b1);
      run(20, 1'b1, 1'b1);
      chk_pops("t3", 16'h1234, 4);

      // 4: redirect near the top of the address space wraps
      lat = 1;
      run(6, 1'b1, 1'b1);
      clear_logs();
      step(1'b1, 16'hFFFE, 1'b1, 1'b1);
      run(12, 1'b1, 1'b1);
      chk_pops("t4", 16'hFFFE, 4);

      // 5: redirect in a steady-state cycle with response, request and pop all active
      run(4, 1'b1, 1'b1);
      clear_logs();
      step(1'b1, 16'h4000, 1'b1, 1'b1);
      run(10, 1'b1, 1'b1);
      chk_pops("t5", 16'h4000, 3);

      // back-to-back redirects: last one wins
      lat = 2;
      run(4, 1'b1, 1'b1);
      clear_logs();
      step(1'b1, 16'h5000, 1'b1, 1'b1);
      step(1'b1, 16'h6000, 1'b1, 1'b1);
      run(12, 1'b1, 1'b1);
      chk_pops("t5b", 16'h6000, 4);

      // 6: reset with buffered bytes and reads in flight
      run(3, 1'b0, 1'b1);
      run(2, 1'b0, 1'b1);
      do_reset();
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      chk("t6_first_cycle_addr", 32'(mem_req_addr), 32'(RESET_PC));
      run(10, 1'b1, 1'b1);
      chk_pops("t6", 16'h0200, 4);

      // random phase
      do_reset();
      for (int i = 0; i < 800; i++) begin
         lat = int'($urandom_range(1, 4));
         if (i == 400) do_reset();
         step($urandom_range(0, 24) == 0, 16'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
